uart_tx_fifo: RTL and testbench

//  8N1 UART transmitter with an input byte FIFO. It is the transmit end of the

---
 rtl/uart_tx_fifo_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte handshake into the UART transmit FIFO.
// master supplies bytes, slave (the FIFO) returns ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// Queued bytes go out back-to-back, LSB first, no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] PEN  = CW'(CPB - 2);
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (CPB < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count_nxt;
  logic          ready_q;
  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          wr_en;
  logic          has_data;
  logic          bit_end;
  logic          pop;

  assign bus.tx_ready = ready_q;
  assign wr_en    = bus.tx_valid && ready_q;
  assign has_data = fifo_count != '0;
  assign bit_end  = baud_cnt == LAST;
  assign pop      = has_data &&
                    ((state == IDLE) ||
                     (state == STOP && bit_end));

  // next occupancy: a write and a pop in the same cycle cancel
  always_comb begin
    count_nxt = fifo_count;
    if (wr_en && !pop)
      count_nxt = fifo_count + NW'(1);
    else if (!wr_en && pop)
      count_nxt = fifo_count - NW'(1);
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_q    <= 1'b1;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      ready_q    <= count_nxt != FULL;
    end
  end

  // FIFO storage; stale entries are harmless once pointers reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.tx_data;
  end

  // frame sequencer: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      tx_done <= (state == STOP) && (baud_cnt == PEN);
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx_out   <= 1'b1;
          if (has_data) begin
            shift   <= mem[rd_ptr];
            state   <= START;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_out   <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx_out  <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (has_data) begin
              shift  <= mem[rd_ptr];
              state  <= START;
              tx_out <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo at 10 clocks per bit.
// Frame-level queue model, line decoder and directed sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 8;
  localparam int FL    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fifo_count;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fifo_count(fifo_count),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] levels;
  } vec_t;

  vec_t tbl [6];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] mq [$];
  bit         m_act;
  int         m_pos;
  logic [7:0] m_byte;

  logic [7:0] rx_q [$];
  bit         rx_on;
  int         rx_cnt;
  logic [7:0] rx_sh;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic lvl(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic tick();
    logic       v;
    logic       r;
    logic [7:0] d;
    bit         acc;
    logic       e_out;
    logic       e_done;
    int         k;
    v = bus.tx_valid;
    d = bus.tx_data;
    r = rst;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (m_act) begin
        m_pos++;
        if (m_pos == FL) begin
          if (mq.size() > 0) begin
            m_byte = mq.pop_front();
            m_pos  = 0;
          end else begin
            m_act = 1'b0;
          end
        end
      end else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_pos  = 0;
      end
      if (acc) mq.push_back(d);
    end
    cyc++;
    #1;
    e_out  = m_act ? lvl(m_byte, m_pos / CPB) : 1'b1;
    e_done = m_act && (m_pos == FL - 1);
    chk($sformatf("cycle%0d", cyc),
        {24'd0, tx_out, tx_busy, tx_done,
         bus.tx_ready, fifo_count},
        {24'd0, e_out, m_act, e_done,
         mq.size() < DEPTH, 4'(mq.size())});
    if (r) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx_out === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 1;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_on && (rx_cnt % CPB) == CPB / 2) begin
      k = rx_cnt / CPB;
      if (k >= 1 && k <= 8) rx_sh[k-1] = tx_out;
      if (k == 9) rx_q.push_back(rx_sh);
    end
    if (rx_on && rx_cnt == FL) rx_on = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    tick();
    rst = 1'b0;
    rx_q.delete();
  endtask

  task automatic wait_done(input int lim,
                           input string nm);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic fill(output int acc);
    logic pr;
    acc = 0;
    bus.tx_valid = 1'b1;
    repeat (20) begin
      bus.tx_data = acc[7:0];
      pr = bus.tx_ready;
      tick();
      if (pr) acc++;
    end
  endtask

  initial begin
    int acc, lows, dones, n, ca, d1, d2, dens;
    bit glitch, gap;
    logic after1;
    logic [9:0] lv;
    logic [7:0] exp4 [4];

    tbl[0] = '{8'hA5, 10'h34A};
    tbl[1] = '{8'h00, 10'h200};
    tbl[2] = '{8'hFF, 10'h3FE};
    tbl[3] = '{8'h01, 10'h202};
    tbl[4] = '{8'h80, 10'h300};
    tbl[5] = '{8'h3C, 10'h278};

    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out",   {31'd0, tx_out},  32'd1);
    chk("rst_busy",  {31'd0, tx_busy}, 32'd0);
    chk("rst_done",  {31'd0, tx_done}, 32'd0);
    chk("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);

    lows = 0;
    dones = 0;
    repeat (1000) begin
      tick();
      if (tx_out !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("idle_low",  lows,  0);
    chk("idle_done", dones, 0);

    for (int i = 0; i < 6; i++) begin
      bus.tx_data  = tbl[i].data;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      tick();
      lv = '0;
      glitch = 1'b0;
      ca = -1;
      dones = 0;
      for (int c = 1; c <= FL; c++) begin
        if ((c - 1) % CPB == 0)
          lv[(c - 1) / CPB] = tx_out;
        else if (tx_out !== lv[(c - 1) / CPB])
          glitch = 1'b1;
        if (tx_done === 1'b1) begin
          dones++;
          ca = c;
        end
        tick();
      end
      chk($sformatf("levels_%0h", tbl[i].data),
          {22'd0, lv}, {22'd0, tbl[i].levels});
      chk("bit_steady", {31'd0, glitch}, 32'd0);
      chk("done_cycle", ca, FL);
      chk("done_pulses", dones, 1);
      chk("busy_after", {31'd0, tx_busy}, 32'd0);
    end

    do_reset();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    tick();
    bus.tx_data  = 8'hFF;
    tick();
    bus.tx_valid = 1'b0;
    d1 = -1;
    d2 = -1;
    gap = 1'b0;
    after1 = 1'bx;
    for (int c = 0; c < 300; c++) begin
      if (d1 >= 0 && c == d1 + 1) after1 = tx_out;
      if (d2 < 0 && tx_busy !== 1'b1) gap = 1'b1;
      if (tx_done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      tick();
    end
    chk("b2b_spacing", d2 - d1, FL);
    chk("b2b_busy_gap", {31'd0, gap}, 32'd0);
    chk("b2b_no_idle", {31'd0, after1}, 32'd0);
    chk("b2b_bytes", rx_q.size(), 2);

    do_reset();
    fill(acc);
    chk("fill_accepted", acc, 9);
    chk("fill_ready", {31'd0, bus.tx_ready}, 32'd0);
    chk("fill_count", {28'd0, fifo_count}, 32'd8);
    bus.tx_valid = 1'b0;
    repeat (9 * FL + 20) tick();
    chk("fill_frames", rx_q.size(), 9);
    n = rx_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("fill_order%0d", i),
          {24'd0, rx_q[i]}, i);

    do_reset();
    fill(acc);
    wait_done(200, "full_done");
    tick();
    chk("pop_count", {28'd0, fifo_count}, 32'd7);
    tick();
    chk("refill_count", {28'd0, fifo_count}, 32'd8);
    bus.tx_valid = 1'b0;
    repeat (10 * FL + 20) tick();
    chk("refill_frames", rx_q.size(), 10);
    n = rx_q.size();
    if (n > 0)
      chk("refill_last", {24'd0, rx_q[n-1]}, 32'h09);

    do_reset();
    exp4[0] = 8'hA1;
    exp4[1] = 8'hB2;
    exp4[2] = 8'hC3;
    exp4[3] = 8'hD4;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tx_data = exp4[i];
      tick();
    end
    bus.tx_valid = 1'b0;
    chk("simul_pre", {28'd0, fifo_count}, 32'd2);
    wait_done(200, "simul_done");
    bus.tx_valid = 1'b1;
    bus.tx_data  = exp4[3];
    tick();
    bus.tx_valid = 1'b0;
    chk("simul_count", {28'd0, fifo_count}, 32'd2);
    repeat (4 * FL) tick();
    chk("simul_frames", rx_q.size(), 4);
    n = rx_q.size();
    for (int i = 0; i < n && i < 4; i++)
      chk($sformatf("simul_order%0d", i),
          {24'd0, rx_q[i]}, {24'd0, exp4[i]});

    do_reset();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    tick();
    bus.tx_data  = 8'h11;
    tick();
    bus.tx_valid = 1'b0;
    n = 0;
    while (!(rx_on && rx_cnt == 43) && n < 200) begin
      tick();
      n++;
    end
    chk("bit3_reached", rx_cnt, 43);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out",   {31'd0, tx_out},  32'd1);
    chk("abort_busy",  {31'd0, tx_busy}, 32'd0);
    chk("abort_count", {28'd0, fifo_count}, 32'd0);
    lows = 0;
    dones = 0;
    repeat (300) begin
      tick();
      if (tx_out !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("abort_low",  lows,  0);
    chk("abort_done", dones, 0);

    do_reset();
    for (int i = 0; i < 6000; i++) begin
      case ((i / 1000) % 3)
        0:       dens = 10;
        1:       dens = 50;
        default: dens = 95;
      endcase
      bus.tx_valid = $urandom_range(0, 99) < dens;
      bus.tx_data  = 8'($urandom);
      rst = $urandom_range(0, 1999) == 0;
      tick();
    end
    rst = 1'b0;
    bus.tx_valid = 1'b0;
    repeat (10 * FL) tick();
    chk("final_busy",  {31'd0, tx_busy}, 32'd0);
    chk("final_count", {28'd0, fifo_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
